// File: rtl/ps2_receiver.sv
// rtl/ps2_receiver.sv - PS/2 device-to-host frame receiver producing strb/code scan bytes
// Optional parity checking is compiled in with `define PS2_PARITY_CHECK_EN.
module ps2_receiver #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       strb,
  output logic [7:0] code,
  output logic       perr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    FILT_LAST = 4'(FILTER - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic          ck_s1, ck_s2, d_s1, d_s2;
  logic          ck_f, ck_f_d, fall;
  logic [3:0]    filt_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit, abort;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          frame_end, byte_ok;
  state_t        state_q, state_d;

  // Two-flop synchronizers for both raw pins; idle level of the bus is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      d_s1  <= 1'b1;
      d_s2  <= 1'b1;
    end else begin
      ck_s1 <= ps2ck;
      ck_s2 <= ck_s1;
      d_s1  <= ps2d;
      d_s2  <= d_s1;
    end
  end

  // Deglitch: filtered clock follows only after FILTER consecutive differing samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_f     <= 1'b1;
      filt_cnt <= 4'd0;
    end else if (ck_s2 != ck_f) begin
      if (filt_cnt == FILT_LAST) begin
        ck_f     <= ck_s2;
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end else begin
      filt_cnt <= 4'd0;
    end
  end

  // Registered one-cycle flag on a 1->0 transition of the filtered clock
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_f_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      ck_f_d <= ck_f;
      fall   <= ck_f_d & ~ck_f;
    end
  end

  assign timeout_hit = (to_cnt == TO_MAX);
  // A fall in the same cycle as the timeout wins, so the abort needs !fall
  assign abort       = (state_q != ST_START) && !fall && timeout_hit;

  // Inter-edge watchdog: runs only inside a frame, cleared by every fall, saturates
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state_q == ST_START || fall) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Frame state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_START;
    else        state_q <= state_d;
  end

  // Frame sequencing: start bit, eight data bits, parity, stop
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_START;
    end else if (fall) begin
      case (state_q)
        ST_START:  if (!d_s2) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_START;
        default:   state_d = ST_START;
      endcase
    end
  end

  // Data shift register (LSB first) and data bit counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (abort) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (fall) begin
      case (state_q)
        ST_START: bit_cnt <= 3'd0;
        ST_DATA: begin
          shreg   <= {d_s2, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // A complete frame is one whose stop bit is sampled high
  assign frame_end = fall && (state_q == ST_STOP) && d_s2;

`ifdef PS2_PARITY_CHECK_EN
  logic par, parity_ok;

  // Capture the parity bit for the odd-parity check at the stop bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           par <= 1'b0;
    else if (abort)                       par <= 1'b0;
    else if (fall && state_q == ST_PARITY) par <= d_s2;
  end

  assign parity_ok = ^{shreg, par};
  assign byte_ok   = frame_end && parity_ok;

  // Parity error pulse lands in the cycle strb would have asserted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) perr <= 1'b0;
    else        perr <= frame_end && !parity_ok;
  end
`else
  assign byte_ok = frame_end;
  assign perr    = 1'b0;
`endif

  // Present a good byte with a single-cycle strobe; code holds until the next one
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strb <= 1'b0;
      code <= 8'h00;
    end else begin
      strb <= byte_ok;
      if (byte_ok) code <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// tb/tb_ps2_receiver.sv - scoreboard testbench for ps2_receiver
module tb_ps2_receiver;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 400;
  localparam int HALF    = 40;

  logic       clock, reset, ps2ck, ps2d;
  logic       strb, perr;
  logic [7:0] code;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         t_last_fall = 0;
  int         perr_seen = 0;
  int         perr_exp  = 0;
  logic [7:0] exp_code  = 8'h00;
  logic [7:0] sb_q[$];

  ps2_receiver #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .ps2ck(ps2ck), .ps2d(ps2d),
    .strb(strb), .code(code), .perr(perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used for latency measurement
  always @(posedge clock) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on each strobe
  always @(negedge clock) begin
    if (reset) begin
      if (strb) begin
        check_eq("strb_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          check_eq("strb_code", code, sb_q.pop_front());
          check_eq("strb_latency", cyc - t_last_fall, FILTER + 4);
        end
      end
      if (perr) begin
        perr_seen++;
        check_eq("perr_latency", cyc - t_last_fall, FILTER + 4);
      end
      if (strb || perr) check_eq("strb_perr_excl", strb && perr, 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip);
    logic p;
    p = (~^d) ^ flip;
    return {1'b1, p, d, 1'b0};
  endfunction

  // Drive nbits of a frame; optional short low glitch in the high phase of one bit
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ps2d = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(HALF / 2);
        ps2ck = 1'b0;
        wait_cyc(FILTER - 1);
        ps2ck = 1'b1;
        wait_cyc(HALF - HALF / 2 - (FILTER - 1));
      end else begin
        wait_cyc(HALF);
      end
      ps2ck = 1'b0;
      if (i == 10) t_last_fall = cyc;
      wait_cyc(HALF);
      ps2ck = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input int glitch_bit);
`ifdef PS2_PARITY_CHECK_EN
    if (flip) perr_exp++;
    else begin
      sb_q.push_back(d);
      exp_code = d;
    end
`else
    sb_q.push_back(d);
    exp_code = d;
`endif
    send_bits(mk_frame(d, flip), 11, glitch_bit);
    wait_cyc(HALF);
    check_eq("code_hold", code, exp_code);
  endtask

  initial begin
    reset = 1'b0;
    ps2ck = 1'b1;
    ps2d  = 1'b1;
    wait_cyc(3);
    check_eq("rst_strb", strb, 0);
    check_eq("rst_code", code, 8'h00);
    check_eq("rst_perr", perr, 0);
    reset = 1'b1;
    wait_cyc(10);

    // Clean A make code
    send_frame(8'h1C, 1'b0, -1);
    // Parity-corrupted frame
    send_frame(8'h29, 1'b1, -1);
    // Back-to-back prefix sequence
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'hF0, 1'b0, -1);
    send_frame(8'h75, 1'b0, -1);

    // Partial frame abandoned by timeout, then a full frame
    send_bits(mk_frame(8'h33, 1'b0), 5, -1);
    wait_cyc(TIMEOUT + 10);
    check_eq("timeout_code_hold", code, exp_code);
    send_frame(8'h5A, 1'b0, -1);

    // Glitch on ps2ck mid-frame
    send_frame(8'h16, 1'b0, 4);
    // Start bit of 1 is ignored
    send_bits(11'h7FF, 1, -1);
    wait_cyc(200);
    check_eq("start1_code_hold", code, 8'h16);

    // Reset in the middle of a frame
    send_bits(mk_frame(8'h66, 1'b0), 7, -1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("midrst_strb", strb, 0);
      check_eq("midrst_code", code, 8'h00);
      check_eq("midrst_perr", perr, 0);
      @(negedge clock);
    end
    ps2d  = 1'b1;
    reset = 1'b1;
    exp_code = 8'h00;
    wait_cyc(20);
    check_eq("postrst_code", code, 8'h00);
    send_frame(8'h45, 1'b0, -1);

    wait_cyc(50);
    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("perr_count", perr_seen, perr_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_receiver.md
Name: ps2_receiver

Overview:
- PS/2 device-to-host serial receiver; sits directly upstream of the keyboard matrix decoder.
- Samples the raw keyboard clock and data lines and assembles 11-bit frames.
- Validates each frame and presents every good scan code byte as an 8-bit `code` with a single-cycle `strb`. These are the exact `strb`/`code` signals the matrix consumes.
- Does not interpret F0/E0 prefixes; every byte is passed through.

Parameters:
- FILTER, 8: number of consecutive equal synchronized samples required before the filtered ps2ck changes level (1..15).
- TIMEOUT, 20000: max clock cycles allowed between filtered ps2ck falling edges inside a frame before the frame is abandoned.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2ck  input  1  raw PS/2 clock pin, asynchronous to clock.
- ps2d  input  1  raw PS/2 data pin, asynchronous to clock.
- strb  output  1  one-cycle pulse: code holds a newly received valid byte.
- code  output  8  last valid received byte; held stable until the next valid frame.
- perr  output  1  one-cycle pulse on a parity-failed frame (see Optional Feature).

Behaviour:
- Reset, asynchronous and active-low:
  - strb=0, code=8'h00, perr=0.
  - Bit counter=0, timeout counter=0.
  - Synchronizers=1, filtered ck=1, filter counter=0.
  - Reset mid-frame discards the partial frame; no strb.
- Input conditioning:
  - ps2ck and ps2d each pass through a 2-flop synchronizer.
  - Filtered ck takes the synchronized level after FILTER consecutive cycles of that level that differ from the current filtered value. Any shorter pulse is ignored.
  - A fall event is a one-cycle flag when filtered ck goes 1->0.
- Frame assembly: on each fall event, sample synchronized ps2d at bit index n (0..10):
  - n=0, start bit: if 1, ignore; stay at n=0 with no error. If 0, advance to n=1.
  - n=1..8: data bits, LSB first, shifted into an 8-bit register.
  - n=9: parity bit; frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - n=10: stop bit; must be 1.
  - After n=10 the counter always returns to 0.
- Output:
  - The cycle after the fall event for n=10, if stop=1 and parity is good (or the parity check is compiled out): code<=data, strb=1 for exactly one cycle.
  - A bad stop bit drops the frame silently; code is unchanged.
- Latency, raw pin edge of the stop-bit falling clock to strb: 2 (sync) + FILTER + 1 (fall flag) + 1 = FILTER+4 cycles.
- Timeout:
  - While n!=0, the timeout counter increments each cycle and clears on every fall event.
  - Reaching TIMEOUT forces n=0 and clears the shift register; no strb, no perr.
  - The counter is held at 0 while n=0.
  - Counter width: ceil(log2(TIMEOUT+1)) bits; saturates, no wrap.
- Simultaneous events: a fall event in the same cycle the counter reaches TIMEOUT is honoured; the fall wins and the timeout is cleared.
- strb and perr are never asserted in the same cycle. Neither can assert again before the next complete frame.
- The block never drives the PS/2 lines; it is receive only.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined:
  - A parity failure on an otherwise complete frame drops the byte: no strb, code unchanged.
  - perr pulses one cycle, at the cycle strb would have asserted.
- Undefined:
  - The parity bit is sampled but ignored; any frame with start=0 and stop=1 produces strb.
  - perr is tied 0.

Test Plan:
- Clean frame for 8'h1C (A make: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12 kHz -> exactly one strb, code=8'h1C, perr=0; strb FILTER+4 cycles after the 11th falling ps2ck edge.
- Back-to-back frames 8'hE0, 8'hF0, 8'h75 -> three strb pulses with code 8'hE0, 8'hF0, 8'h75 in order; code holds each value between pulses.
- Frame 8'h29 with parity bit inverted:
  - Macro defined -> no strb, code stays at previous 8'h1C, one perr pulse.
  - Macro undefined -> strb with code=8'h29, perr=0.
- Send 5 bits of a frame, then idle TIMEOUT+10 cycles, then a full 8'h5A frame -> no strb for the partial frame; one strb with code=8'h5A.
- Inject a ps2ck low glitch of FILTER-1 cycles mid-frame during an 8'h16 frame -> glitch ignored; strb with code=8'h16. A start bit of 1 with no further edges -> no strb.
- Assert reset low for 3 cycles after bit 6 of an 8'h66 frame, release, then send a full 8'h45 frame -> strb=0, code=8'h00 during reset; the partial frame is discarded; then one strb with code=8'h45.
